instr_mem_ctrl_core: RTL and testbench



---
 rtl/instr_mem_ctrl_core_pkg.sv | 20 ++
 rtl/instr_mem_ctrl_core_leb128_len.sv | 15 +
 rtl/instr_mem_ctrl_core.sv | 113 +++++++++++
 tb/tb_instr_mem_ctrl_core.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_ctrl_core_pkg.sv
// rtl/instr_mem_ctrl_core_pkg.sv - shared geometry and WASM opcode constants for the instruction memory
package instr_mem_ctrl_core_pkg;

  localparam int INSTR_LOG2_BRAM_DEPTH = 6;
  localparam int INSTR_BRAM_WIDTH      = 256;
  localparam int INSTR_BRAM_DEPTH      = 64;
  localparam int INSTR_WRITE_WIDTH     = 256;
  localparam int INSTR_READ_WIDTH      = 64;

  localparam logic [7:0] OP_BLOCK = 8'h02;
  localparam logic [7:0] OP_LOOP  = 8'h03;
  localparam logic [7:0] OP_IF    = 8'h04;
  localparam logic [7:0] OP_END   = 8'h0B;

  // Opcodes that open a structured block closed later by OP_END.
  function automatic logic opens_block(input logic [7:0] op);
    return (op == OP_BLOCK) || (op == OP_LOOP) || (op == OP_IF);
  endfunction

endpackage

// File: rtl/instr_mem_ctrl_core_leb128_len.sv
// rtl/instr_mem_ctrl_core_leb128_len.sv - length (1..5) of a LEB128 field from its first clear bit 7
module leb128_len (
  input  logic [39:0] imm_bytes,
  output logic [2:0]  len
);

  // Scan from the top so the lowest terminating byte wins; no terminator caps at the i32 maximum.
  always_comb begin
    len = 3'd5;
    for (int i = 4; i >= 0; i--) begin
      if (!imm_bytes[8*i+7]) len = 3'(i + 1);
    end
  end

endmodule

// File: rtl/instr_mem_ctrl_core.sv
// rtl/instr_mem_ctrl_core.sv - bytecode store with byte-granular read window, opcode/LEB advance and end detection
module instr_mem_ctrl_core
  import instr_mem_ctrl_core_pkg::*;
#(
  parameter int ADDR_WIDTH = INSTR_LOG2_BRAM_DEPTH,
  parameter int DATA_WIDTH = INSTR_BRAM_WIDTH,
  parameter int DEPTH      = INSTR_BRAM_DEPTH,
  parameter int WR_WIDTH   = INSTR_WRITE_WIDTH,
  parameter int RD_WIDTH   = INSTR_READ_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_mode,
  input  logic                  mode_vld,
  input  logic                  re,
  output logic [RD_WIDTH-1:0]   rd_data,
  output logic                  rd_data_vld,
  input  logic                  we,
  input  logic [WR_WIDTH-1:0]   wr_data,
  output logic                  instr_finish,
  output logic [ADDR_WIDTH-1:0] read_pointer,
  output logic [ADDR_WIDTH-1:0] write_pointer
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int OFF_W          = $clog2(BYTES_PER_WORD);
  localparam int BP_W           = ADDR_WIDTH + OFF_W + 1;
  localparam int RD_BYTES       = RD_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]     wr_cnt;
  logic [BP_W-1:0]         bp;
  logic [BP_W-1:0]         written;
  logic [BP_W-1:0]         adv;
  logic [BP_W-1:0]         adv_sum;
  logic [BP_W-1:0]         bp_nxt;
  logic [7:0]              nest;
  logic                    wr_full;
  logic                    has_unread;
  logic [ADDR_WIDTH-1:0]   bp_word;
  logic [ADDR_WIDTH-1:0]   bp_word_nx;
  logic [2*DATA_WIDTH-1:0] pair;
  logic [RD_WIDTH-1:0]     win_raw;
  logic [RD_WIDTH-1:0]     win;
  logic [2:0]              leb_len;
  logic [7:0]              op;

  assign written    = {wr_cnt, {OFF_W{1'b0}}};
  assign wr_full    = (wr_cnt == (ADDR_WIDTH+1)'(DEPTH));
  assign has_unread = (bp < written);

  // The window may straddle a word boundary, so fetch the word pair and byte-shift.
  assign bp_word    = bp[BP_W-2:OFF_W];
  assign bp_word_nx = bp_word + 1'b1;
  assign pair       = {mem[bp_word_nx], mem[bp_word]};
  assign win_raw    = RD_WIDTH'(pair >> {bp[OFF_W-1:0], 3'b000});

  always_comb begin
    win = '0;
    for (int i = 0; i < RD_BYTES; i++) begin
      if ((bp + BP_W'(i)) < written) win[8*i +: 8] = win_raw[8*i +: 8];
    end
  end

  leb128_len u_leb (
    .imm_bytes (win[47:8]),
    .len       (leb_len)
  );

  assign op      = win[7:0];
  assign adv     = shift_mode ? (BP_W'(leb_len) + BP_W'(1)) : BP_W'(1);
  assign adv_sum = bp + adv;
  assign bp_nxt  = (adv_sum > written) ? written : adv_sum;

  always_ff @(posedge clk) begin
    if (we && !wr_full) mem[wr_cnt[ADDR_WIDTH-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt       <= '0;
      bp           <= '0;
      nest         <= '0;
      instr_finish <= 1'b0;
      rd_data      <= '0;
      rd_data_vld  <= 1'b0;
    end else begin
      if (we && !wr_full) wr_cnt <= wr_cnt + 1'b1;

      if (re && has_unread) begin
        rd_data     <= win;
        rd_data_vld <= 1'b1;
      end else begin
        rd_data_vld <= 1'b0;
      end

      if (mode_vld && !instr_finish) begin
        bp <= bp_nxt;
        if (opens_block(op)) begin
          nest <= nest + 1'b1;
        end else if (op == OP_END) begin
          if (nest != 8'd0) nest <= nest - 1'b1;
          else              instr_finish <= 1'b1;
        end
      end
    end
  end

  assign read_pointer  = bp[BP_W-2:OFF_W];
  assign write_pointer = wr_cnt[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_instr_mem_ctrl_core.sv
// tb/tb_instr_mem_ctrl_core.sv - directed self-checking bench for instr_mem_ctrl_core
module tb_instr_mem_ctrl_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         shift_mode = 1'b0;
  logic         mode_vld = 1'b0;
  logic         re = 1'b0;
  logic [63:0]  rd_data;
  logic         rd_data_vld;
  logic         we = 1'b0;
  logic [255:0] wr_data = '0;
  logic         instr_finish;
  logic [5:0]   read_pointer;
  logic [5:0]   write_pointer;

  int total = 0;
  int bad   = 0;

  instr_mem_ctrl_core dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .shift_mode    (shift_mode),
    .mode_vld      (mode_vld),
    .re            (re),
    .rd_data       (rd_data),
    .rd_data_vld   (rd_data_vld),
    .we            (we),
    .wr_data       (wr_data),
    .instr_finish  (instr_finish),
    .read_pointer  (read_pointer),
    .write_pointer (write_pointer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic wr(input logic [255:0] d);
    we = 1'b1;
    wr_data = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic rd();
    re = 1'b1;
    cyc();
    re = 1'b0;
  endtask

  task automatic adv(input logic m);
    mode_vld = 1'b1;
    shift_mode = m;
    cyc();
    mode_vld = 1'b0;
    shift_mode = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_rd_data", rd_data, 0);
    check("rst_vld", rd_data_vld, 0);
    check("rst_finish", instr_finish, 0);
    check("rst_rp", read_pointer, 0);
    check("rst_wp", write_pointer, 0);

    rd();
    check("empty_re_vld", rd_data_vld, 0);

    // local.get 0; local.get 1; i32.add; end
    wr(256'h0b6a01200020);
    check("load_wp", write_pointer, 1);
    rd();
    check("load_vld", rd_data_vld, 1);
    check("load_data", rd_data, 64'h00000b6a01200020);
    cyc();
    check("vld_pulse", rd_data_vld, 0);

    re = 1'b1;
    adv(1'b1);
    re = 1'b0;
    check("re_adv_pre_window", rd_data, 64'h00000b6a01200020);
    check("leb_bp2", dut.bp, 2);
    rd();
    check("bp2_data", rd_data, 64'h000000000b6a0120);

    adv(1'b1);
    check("bp4", dut.bp, 4);
    adv(1'b0);
    check("bp5_no_finish", instr_finish, 0);
    adv(1'b0);
    check("finish_set", instr_finish, 1);
    check("bp6", dut.bp, 6);
    adv(1'b1);
    adv(1'b0);
    check("bp_frozen", dut.bp, 6);
    check("finish_sticky", instr_finish, 1);

    // block 0x40; end; end
    do_reset();
    wr(256'h0b0b4002);
    adv(1'b1);
    check("nest_bp2", dut.bp, 2);
    adv(1'b0);
    check("nest_inner_end", instr_finish, 0);
    adv(1'b0);
    check("nest_outer_end", instr_finish, 1);

    // i32.const with a 3-byte LEB straddling word0/word1, then end
    do_reset();
    wr({8'hE5, 8'h41, 240'h0});
    wr(256'h0b268e);
    for (int i = 0; i < 30; i++) adv(1'b0);
    check("strad_bp30", dut.bp, 30);
    check("strad_rp0", read_pointer, 0);
    rd();
    check("strad_data", rd_data, 64'h0000000b268ee541);
    adv(1'b1);
    check("strad_bp34", dut.bp, 34);
    check("strad_rp1", read_pointer, 1);
    check("strad_no_finish", instr_finish, 0);
    adv(1'b0);
    check("strad_finish", instr_finish, 1);

    // LEB cap at 5 and clamp to the written byte count
    do_reset();
    wr({256{1'b1}});
    adv(1'b1);
    check("leb_cap_bp6", dut.bp, 6);
    for (int i = 0; i < 25; i++) adv(1'b0);
    rd();
    check("tail_data", rd_data, 64'h00000000000000ff);
    adv(1'b1);
    check("clamp_bp32", dut.bp, 32);
    rd();
    check("drained_vld", rd_data_vld, 0);
    check("drained_hold", rd_data, 64'h00000000000000ff);

    // Fill every slot, then an extra write must not wrap onto word 0
    do_reset();
    wr(256'hA5A5_0000_1234_5678);
    for (int i = 1; i < 63; i++) wr(256'(i));
    check("wp63", write_pointer, 63);
    wr(256'h77);
    check("wp_full", dut.wr_cnt, 64);
    wr({256{1'b1}});
    check("wp_no_wrap", dut.wr_cnt, 64);
    rd();
    check("full_word0", rd_data, 64'hA5A5_0000_1234_5678);

    // Async reset right after a read is accepted
    re = 1'b1;
    cyc();
    re = 1'b0;
    check("midrd_vld", rd_data_vld, 1);
    rst_n = 1'b0;
    #1;
    check("midrd_rst_vld", rd_data_vld, 0);
    check("midrd_rst_data", rd_data, 0);
    check("midrd_rst_wp", write_pointer, 0);
    check("midrd_rst_rp", read_pointer, 0);
    check("midrd_rst_finish", instr_finish, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
